// File: rtl/mux_16to1_task_pkg.sv
// Shared constants for the 16:1 single-bit multiplexer.
// The tree is two levels of 4:1 stages, so N_GRP groups are reduced in level 1.
package mux_16to1_task_pkg;

    localparam int N_IN   = 16;
    localparam int SEL_W  = 4;
    localparam int GRP_SZ = 4;
    localparam int N_GRP  = N_IN / GRP_SZ;

endpackage : mux_16to1_task_pkg

// File: rtl/mux_16to1_task.sv
// 16:1 single-bit mux, registered output with one-cycle latency.
// Built as a two-level tree of 4:1 stages, the stage being a local automatic task.
module mux_16to1_task
    import mux_16to1_task_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [0:N_IN-1]  W,
    input  logic [SEL_W-1:0] S16,
    output logic             f
);

    logic [N_GRP-1:0] lvl1_m;
    logic             f_d;
    logic             f_q;

    // 4:1 stage: y = d[s]
    task automatic mux4(
        input  logic       d0,
        input  logic       d1,
        input  logic       d2,
        input  logic       d3,
        input  logic [1:0] s,
        output logic       y
    );
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = 1'bx;
        endcase
    endtask

    // Selection tree: low select bits pick within each group, high bits pick the group.
    // W is ascending, so W[4*i] is the first entry of group i.
    always_comb begin
        lvl1_m = '0;
        f_d    = 1'b0;
        for (int i = 0; i < N_GRP; i++) begin
            mux4(W[GRP_SZ*i], W[GRP_SZ*i+1], W[GRP_SZ*i+2], W[GRP_SZ*i+3],
                 S16[1:0], lvl1_m[i]);
        end
        mux4(lvl1_m[0], lvl1_m[1], lvl1_m[2], lvl1_m[3], S16[3:2], f_d);
    end

    // Output register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q <= 1'b0;
        end else begin
            f_q <= f_d;
        end
    end

    assign f = f_q;

endmodule : mux_16to1_task

// File: tb/tb_mux_16to1_task.sv
// Self-checking bench for mux_16to1_task: directed cases plus random traffic
// against a reference that treats W as a 16-bit number with W[0] as its MSB.
module tb_mux_16to1_task;

    logic        clk;
    logic        rst;
    logic [0:15] w_in;
    logic [3:0]  s_in;
    logic        f;

    int n_checks;
    int n_errors;
    logic prev_exp;
    bit   have_prev;

    mux_16to1_task dut (
        .clk (clk),
        .rst (rst),
        .W   (w_in),
        .S16 (s_in),
        .f   (f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference: S16 = k picks W[k]; W[0] is bit 15 of the numeric value.
    function automatic logic ref_pick(input logic [15:0] wv, input logic [3:0] s, input logic r);
        int sh;
        if (r) return 1'b0;
        sh = 15 - int'(s);
        return 1'((wv >> sh) & 16'd1);
    endfunction

    // Drive one input set, confirm f has not moved before the edge, then check after it.
    task automatic step(input string tag, input logic [15:0] wv, input logic [3:0] s, input logic r);
        logic e;
        rst  = r;
        w_in = wv;
        s_in = s;
        #1;
        if (have_prev) check_bit({tag, "_hold"}, f, prev_exp);
        @(posedge clk);
        #1;
        e = ref_pick(wv, s, r);
        check_bit(tag, f, e);
        prev_exp  = e;
        have_prev = 1'b1;
    endtask

    initial begin
        logic [15:0] wv;
        n_checks  = 0;
        n_errors  = 0;
        have_prev = 1'b0;
        prev_exp  = 1'b0;
        rst  = 1'b1;
        w_in = 16'hFFFF;
        s_in = 4'hF;
        @(negedge clk);

        // Reset held for several edges with all-ones data
        for (int i = 0; i < 3; i++) step("reset", 16'hFFFF, 4'hF, 1'b1);

        // Alternating pattern walk
        for (int k = 0; k < 16; k++) step("walk", 16'b0101_0101_0101_0101, 4'(k), 1'b0);

        // One-hot sweep over both tree levels
        for (int k = 0; k < 16; k++) begin
            wv = 16'h8000 >> k;
            for (int s = 0; s < 16; s++) step("onehot", wv, 4'(s), 1'b0);
        end

        // Bit order
        step("order_s0", 16'h8000, 4'd0, 1'b0);
        step("order_s15", 16'h8000, 4'd15, 1'b0);

        // Mid-stream reset pulse
        step("mid_pre", 16'hFFFF, 4'd5, 1'b0);
        step("mid_rst", 16'hFFFF, 4'd5, 1'b1);
        step("mid_post", 16'hFFFF, 4'd5, 1'b0);

        // Data and select change on the same edge
        step("same_a", 16'h0000, 4'd3, 1'b0);
        step("same_b", 16'h0001, 4'd15, 1'b0);

        // Random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            step("rand", 16'($urandom), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mux_16to1_task
